// File: rtl/wci_ctl_sequencer_if.sv
// wci_ctl_sequencer_if: host request/response handshake plus the shared and
// per-worker WCI (OCP) signals of the control sequencer.
// The "master" modport is the sequencer's view (it masters the WCI bus).
// The "slave" modport is the environment's view (host plus eight workers).
interface wci_ctl_sequencer_if;

    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_worker;
    logic         req_write;
    logic         req_space;
    logic [31:0]  req_addr;
    logic [31:0]  req_data;
    logic [3:0]   req_byteen;

    logic         rsp_valid;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_status;

    logic [23:0]  wci_MCmd;
    logic         wci_MAddrSpace;
    logic [3:0]   wci_MByteEn;
    logic [31:0]  wci_MAddr;
    logic [31:0]  wci_MData;
    logic [15:0]  wci_SResp;
    logic [255:0] wci_SData;
    logic [7:0]   wci_SThreadBusy;

    modport master (
        input  req_valid, req_worker, req_write, req_space, req_addr, req_data, req_byteen,
        input  wci_SResp, wci_SData, wci_SThreadBusy,
        output req_ready, rsp_valid, rsp_data, rsp_status,
        output wci_MCmd, wci_MAddrSpace, wci_MByteEn, wci_MAddr, wci_MData
    );

    modport slave (
        output req_valid, req_worker, req_write, req_space, req_addr, req_data, req_byteen,
        output wci_SResp, wci_SData, wci_SThreadBusy,
        input  req_ready, rsp_valid, rsp_data, rsp_status,
        input  wci_MCmd, wci_MAddrSpace, wci_MByteEn, wci_MAddr, wci_MData
    );

endinterface

// File: rtl/wci_ctl_sequencer.sv
// wci_ctl_sequencer: takes one host request at a time and issues it as a single
// OCP read or write on one of eight WCI worker ports. It waits out thread-busy,
// then the response, and completes with OK, ERR, TIMEOUT or FENCED. A worker
// that times out is fenced (worker_dead) until clear_dead is pulsed.
// Optional feature: define WCI_SEQ_TOCOUNT_EN to enable the saturating
// timeout_count statistic; without it timeout_count is tied to 0.
module wci_ctl_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                CLK,
    input  logic                RST_N,
    wci_ctl_sequencer_if.master bus,
    input  logic                clear_dead,
    output logic [7:0]          worker_dead,
    output logic [15:0]         timeout_count
);

    typedef enum logic [2:0] {
        IDLE,
        BUSYWAIT,
        CMD,
        RESP,
        DONE
    } stateT;

    localparam logic [1:0]  STATUS_OK      = 2'd0;
    localparam logic [1:0]  STATUS_ERR     = 2'd1;
    localparam logic [1:0]  STATUS_TIMEOUT = 2'd2;
    localparam logic [1:0]  STATUS_FENCED  = 2'd3;

    localparam logic [1:0]  SRESP_NULL = 2'd0;
    localparam logic [1:0]  SRESP_DVA  = 2'd1;
    localparam logic [1:0]  SRESP_FAIL = 2'd2;
    localparam logic [1:0]  SRESP_ERR  = 2'd3;

    localparam logic [2:0]  MCMD_WR = 3'd1;
    localparam logic [2:0]  MCMD_RD = 3'd2;

    // Last counter value of a wait phase; reaching it means TIMEOUT_CYCLES cycles elapsed.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    stateT       state;
    logic [2:0]  curWorker;
    logic        curWrite;
    logic        curFenced;
    logic [15:0] waitCount;

    logic        reqReady;
    logic        rspValid;
    logic [31:0] rspData;
    logic [1:0]  rspStatus;
    logic [7:0]  workerDead;

    logic [23:0] mCmd;
    logic        mAddrSpace;
    logic [3:0]  mByteEn;
    logic [31:0] mAddr;
    logic [31:0] mData;

    logic        laneBusy;
    logic [1:0]  laneResp;
    logic [31:0] laneData;
    logic        waitExpired;

    // Only the latched worker's lane is ever looked at; other lanes are ignored.
    assign laneBusy    = bus.wci_SThreadBusy[curWorker];
    assign laneResp    = bus.wci_SResp[{curWorker, 1'b0} +: 2];
    assign laneData    = bus.wci_SData[{curWorker, 5'b0} +: 32];
    assign waitExpired = (waitCount == WAIT_LAST);

    // Request sequencing FSM with all host and bus outputs registered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            curWorker  <= '0;
            curWrite   <= 1'b0;
            curFenced  <= 1'b0;
            waitCount  <= '0;
            reqReady   <= 1'b1;
            rspValid   <= 1'b0;
            rspData    <= '0;
            rspStatus  <= STATUS_OK;
            workerDead <= '0;
            mCmd       <= '0;
            mAddrSpace <= 1'b0;
            mByteEn    <= '0;
            mAddr      <= '0;
            mData      <= '0;
        end else begin
            rspValid <= 1'b0;
            // A timeout bit set later in this block overrides this clear.
            if (clear_dead) begin
                workerDead <= '0;
            end
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        curWorker  <= bus.req_worker;
                        curWrite   <= bus.req_write;
                        curFenced  <= workerDead[bus.req_worker];
                        waitCount  <= '0;
                        reqReady   <= 1'b0;
                        mAddrSpace <= bus.req_space;
                        mByteEn    <= bus.req_byteen;
                        mAddr      <= bus.req_addr;
                        mData      <= bus.req_data;
                        state      <= BUSYWAIT;
                    end
                end
                BUSYWAIT: begin
                    // A fenced request never touches the bus; it completes after one hold cycle.
                    if (curFenced) begin
                        rspStatus <= STATUS_FENCED;
                        rspData   <= '0;
                        rspValid  <= 1'b1;
                        state     <= DONE;
                    end else if (!laneBusy) begin
                        mCmd  <= {21'd0, curWrite ? MCMD_WR : MCMD_RD} << (5'd3 * {2'd0, curWorker});
                        state <= CMD;
                    end else if (waitExpired) begin
                        rspStatus             <= STATUS_TIMEOUT;
                        rspData               <= '0;
                        rspValid              <= 1'b1;
                        workerDead[curWorker] <= 1'b1;
                        state                 <= DONE;
                    end else begin
                        waitCount <= waitCount + 16'd1;
                    end
                end
                CMD: begin
                    mCmd      <= '0;
                    waitCount <= '0;
                    state     <= RESP;
                end
                RESP: begin
                    case (laneResp)
                        SRESP_DVA: begin
                            rspStatus <= STATUS_OK;
                            rspData   <= curWrite ? 32'd0 : laneData;
                            rspValid  <= 1'b1;
                            state     <= DONE;
                        end
                        SRESP_FAIL, SRESP_ERR: begin
                            rspStatus <= STATUS_ERR;
                            rspData   <= '0;
                            rspValid  <= 1'b1;
                            state     <= DONE;
                        end
                        SRESP_NULL: begin
                            if (waitExpired) begin
                                rspStatus             <= STATUS_TIMEOUT;
                                rspData               <= '0;
                                rspValid              <= 1'b1;
                                workerDead[curWorker] <= 1'b1;
                                state                 <= DONE;
                            end else begin
                                waitCount <= waitCount + 16'd1;
                            end
                        end
                    endcase
                end
                DONE: begin
                    reqReady   <= 1'b1;
                    mAddrSpace <= 1'b0;
                    mByteEn    <= '0;
                    mAddr      <= '0;
                    mData      <= '0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef WCI_SEQ_TOCOUNT_EN
    logic [15:0] timeoutCount;

    // Count TIMEOUT completions (seen on the completion strobe), saturating at all-ones.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            timeoutCount <= '0;
        end else if (rspValid && (rspStatus == STATUS_TIMEOUT) && (timeoutCount != 16'hFFFF)) begin
            timeoutCount <= timeoutCount + 16'd1;
        end
    end

    assign timeout_count = timeoutCount;
`else
    assign timeout_count = '0;
`endif

    assign worker_dead        = workerDead;
    assign bus.req_ready      = reqReady;
    assign bus.rsp_valid      = rspValid;
    assign bus.rsp_data       = rspData;
    assign bus.rsp_status     = rspStatus;
    assign bus.wci_MCmd       = mCmd;
    assign bus.wci_MAddrSpace = mAddrSpace;
    assign bus.wci_MByteEn    = mByteEn;
    assign bus.wci_MAddr      = mAddr;
    assign bus.wci_MData      = mData;

endmodule

// File: tb/tb_wci_ctl_sequencer.sv
// tb_wci_ctl_sequencer: directed-vector bench for wci_ctl_sequencer with
// TIMEOUT_CYCLES=16 and a small per-lane worker responder.
`timescale 1ns/1ps
module tb_wci_ctl_sequencer;

    localparam int TO = 16;

    localparam logic [1:0] SR_NULL = 2'd0;
    localparam logic [1:0] SR_DVA  = 2'd1;
    localparam logic [1:0] SR_ERR  = 2'd3;

`ifdef WCI_SEQ_TOCOUNT_EN
    localparam bit TOCOUNT = 1'b1;
`else
    localparam bit TOCOUNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstN;
    logic        clearDead;
    logic [7:0]  workerDead;
    logic [15:0] timeoutCount;

    int checks;
    int errors;

    logic [1:0] laneCode [8];
    int         respDelay [8];
    int         pend [8] = '{default: 0};
    logic       injectLane4 = 1'b0;

    logic [31:0] gotLat, gotStatus, gotData, gotValid;
    logic [31:0] cmdCount, cmdValue, cmdAddr, cmdData, cmdSpace, cmdBe;
    logic [31:0] readyBusy, afterValid, afterReady, afterAddr;
    logic [31:0] deadAtDone, deadAfter, toAfter;

    wci_ctl_sequencer_if bus();

    wci_ctl_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK          (clk),
        .RST_N        (rstN),
        .bus          (bus),
        .clear_dead   (clearDead),
        .worker_dead  (workerDead),
        .timeout_count(timeoutCount)
    );

    always #5 clk = ~clk;

    // Worker model: answer a lane respDelay cycles after its MCmd cycle, for one cycle.
    always @(negedge clk) begin
        logic [15:0] nextResp;
        nextResp = '0;
        for (int i = 0; i < 8; i++) begin
            if (pend[i] == 1) nextResp[2*i +: 2] = laneCode[i];
            if (pend[i] != 0) pend[i] = pend[i] - 1;
            if (bus.wci_MCmd[3*i +: 3] != 3'd0) pend[i] = respDelay[i];
        end
        if (injectLane4) nextResp[9:8] = SR_DVA;
        bus.wci_SResp = nextResp;
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] toExp(input int n);
        return TOCOUNT ? 32'(n) : 32'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one request and record what the bus and host side showed until completion.
    task automatic applyStimulus(input logic [2:0] worker, input logic write, input logic space,
                                 input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        int lat;
        @(negedge clk);
        bus.req_worker = worker;
        bus.req_write  = write;
        bus.req_space  = space;
        bus.req_addr   = addr;
        bus.req_data   = data;
        bus.req_byteen = be;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        readyBusy = 32'(bus.req_ready);
        cmdCount = 0; cmdValue = 0; cmdAddr = 0; cmdData = 0; cmdSpace = 0; cmdBe = 0;
        gotValid = 0; gotLat = 0; gotStatus = 0; gotData = 0; deadAtDone = 0;
        if (bus.wci_MCmd != 24'd0) cmdCount = cmdCount + 1;
        lat = 0;
        while (gotValid == 0 && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.wci_MCmd != 24'd0) begin
                cmdCount = cmdCount + 1;
                cmdValue = 32'(bus.wci_MCmd);
                cmdAddr  = bus.wci_MAddr;
                cmdData  = bus.wci_MData;
                cmdSpace = 32'(bus.wci_MAddrSpace);
                cmdBe    = 32'(bus.wci_MByteEn);
            end
            if (bus.rsp_valid) begin
                gotValid   = 1;
                gotLat     = 32'(lat);
                gotStatus  = 32'(bus.rsp_status);
                gotData    = bus.rsp_data;
                deadAtDone = 32'(workerDead);
            end
        end
        checkOutput("rspSeen", gotValid, 1);
        @(negedge clk);
        afterValid = 32'(bus.rsp_valid);
        afterReady = 32'(bus.req_ready);
        afterAddr  = bus.wci_MAddr;
        deadAfter  = 32'(workerDead);
        toAfter    = 32'(timeoutCount);
    endtask

    initial begin
        logic [31:0] seen;
        checks = 0;
        errors = 0;
        rstN = 1'b0;
        clearDead = 1'b0;
        bus.req_valid = 1'b0; bus.req_worker = '0; bus.req_write = 1'b0; bus.req_space = 1'b0;
        bus.req_addr = '0; bus.req_data = '0; bus.req_byteen = '0;
        bus.wci_SThreadBusy = '0;
        bus.wci_SData = '0;
        for (int i = 0; i < 8; i++) begin
            laneCode[i]  = SR_DVA;
            respDelay[i] = 1;
        end
        bus.wci_SData[32*0 +: 32] = 32'hDEADBEEF;
        bus.wci_SData[32*3 +: 32] = 32'hCAFEF00D;
        bus.wci_SData[32*4 +: 32] = 32'h44444444;
        bus.wci_SData[32*5 +: 32] = 32'h55AA55AA;

        // Reset values, while reset is held and after release.
        repeat (3) @(negedge clk);
        checkOutput("rstReqReady", 32'(bus.req_ready), 1);
        checkOutput("rstRspValid", 32'(bus.rsp_valid), 0);
        checkOutput("rstRspStatus", 32'(bus.rsp_status), 0);
        checkOutput("rstRspData", bus.rsp_data, 0);
        checkOutput("rstMCmd", 32'(bus.wci_MCmd), 0);
        checkOutput("rstMAddr", bus.wci_MAddr, 0);
        checkOutput("rstWorkerDead", 32'(workerDead), 0);
        checkOutput("rstTimeoutCount", 32'(timeoutCount), 0);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("idleReqReady", 32'(bus.req_ready), 1);

        // Read worker 3, best-case latency.
        applyStimulus(3'd3, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
        checkOutput("rdLatency", gotLat, 3);
        checkOutput("rdCmdCycles", cmdCount, 1);
        checkOutput("rdCmdLanes", cmdValue, 32'h400);
        checkOutput("rdCmdAddr", cmdAddr, 32'h10);
        checkOutput("rdStatus", gotStatus, 0);
        checkOutput("rdData", gotData, 32'hCAFEF00D);
        checkOutput("rdReadyWhileBusy", readyBusy, 0);
        checkOutput("rdValidOneCycle", afterValid, 0);
        checkOutput("rdReadyAfter", afterReady, 1);
        checkOutput("rdAddrIdle", afterAddr, 0);

        // Write worker 0, configuration space.
        applyStimulus(3'd0, 1'b1, 1'b1, 32'h44, 32'h12345678, 4'hF);
        checkOutput("wrLatency", gotLat, 3);
        checkOutput("wrCmdLanes", cmdValue, 32'h1);
        checkOutput("wrCmdData", cmdData, 32'h12345678);
        checkOutput("wrCmdSpace", cmdSpace, 1);
        checkOutput("wrCmdByteEn", cmdBe, 32'hF);
        checkOutput("wrStatus", gotStatus, 0);
        checkOutput("wrData", gotData, 0);

        // Worker 5 stuck busy: busy-phase timeout and fence.
        bus.wci_SThreadBusy[5] = 1'b1;
        applyStimulus(3'd5, 1'b0, 1'b0, 32'h50, 32'h0, 4'hF);
        bus.wci_SThreadBusy[5] = 1'b0;
        checkOutput("busyToLatency", gotLat, TO);
        checkOutput("busyToCmdCycles", cmdCount, 0);
        checkOutput("busyToStatus", gotStatus, 2);
        checkOutput("busyToDead", deadAfter, 32'h20);
        checkOutput("busyToCount", toAfter, toExp(1));

        // Fenced worker 5: immediate completion, no bus activity.
        applyStimulus(3'd5, 1'b0, 1'b0, 32'h54, 32'h0, 4'hF);
        checkOutput("fenceLatency", gotLat, 1);
        checkOutput("fenceStatus", gotStatus, 3);
        checkOutput("fenceCmdCycles", cmdCount, 0);
        checkOutput("fenceData", gotData, 0);

        // clear_dead pulse unfences worker 5.
        @(negedge clk);
        clearDead = 1'b1;
        @(negedge clk);
        clearDead = 1'b0;
        checkOutput("clearDead", 32'(workerDead), 0);
        applyStimulus(3'd5, 1'b0, 1'b0, 32'h58, 32'h0, 4'hF);
        checkOutput("unfenceStatus", gotStatus, 0);
        checkOutput("unfenceLatency", gotLat, 3);
        checkOutput("unfenceCmdLanes", cmdValue, 32'h10000);
        checkOutput("unfenceData", gotData, 32'h55AA55AA);

        // Worker 2 answers ERR late while lane 4 shows a stray DVA.
        laneCode[2]  = SR_ERR;
        respDelay[2] = 4;
        injectLane4  = 1'b1;
        applyStimulus(3'd2, 1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
        injectLane4  = 1'b0;
        laneCode[2]  = SR_DVA;
        respDelay[2] = 1;
        checkOutput("errCmdLanes", cmdValue, 32'h80);
        checkOutput("errLatency", gotLat, 6);
        checkOutput("errStatus", gotStatus, 1);
        checkOutput("errData", gotData, 0);
        checkOutput("errDead", deadAfter, 0);

        // Worker 6 never answers: response-phase timeout.
        laneCode[6] = SR_NULL;
        applyStimulus(3'd6, 1'b0, 1'b0, 32'h60, 32'h0, 4'hF);
        laneCode[6] = SR_DVA;
        checkOutput("respToCmdLanes", cmdValue, 32'h80000);
        checkOutput("respToLatency", gotLat, TO + 2);
        checkOutput("respToStatus", gotStatus, 2);
        checkOutput("respToDead", deadAfter, 32'h40);
        checkOutput("respToCount", toAfter, toExp(2));

        // Timeout on worker 7 with clear_dead held: set wins, then the clear applies.
        bus.wci_SThreadBusy[7] = 1'b1;
        clearDead = 1'b1;
        applyStimulus(3'd7, 1'b1, 1'b0, 32'h70, 32'hA5A5A5A5, 4'h3);
        clearDead = 1'b0;
        bus.wci_SThreadBusy[7] = 1'b0;
        checkOutput("prioStatus", gotStatus, 2);
        checkOutput("prioDeadAtDone", deadAtDone, 32'h80);
        checkOutput("prioDeadAfter", deadAfter, 0);
        checkOutput("prioCount", toAfter, toExp(3));

        // Reset asserted during RESP of a worker 1 read.
        laneCode[1] = SR_NULL;
        @(negedge clk);
        bus.req_worker = 3'd1; bus.req_write = 1'b0; bus.req_space = 1'b1;
        bus.req_addr = 32'h20; bus.req_data = 32'h0; bus.req_byteen = 4'hF;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (bus.wci_MCmd != 24'd0) seen = 1;
        end
        checkOutput("midRstCmdSeen", seen, 1);
        @(negedge clk);
        checkOutput("midRstAddrBefore", bus.wci_MAddr, 32'h20);
        #1 rstN = 1'b0;
        #1;
        checkOutput("midRstReqReady", 32'(bus.req_ready), 1);
        checkOutput("midRstRspValid", 32'(bus.rsp_valid), 0);
        checkOutput("midRstMCmd", 32'(bus.wci_MCmd), 0);
        checkOutput("midRstMAddr", bus.wci_MAddr, 0);
        checkOutput("midRstSpace", 32'(bus.wci_MAddrSpace), 0);
        checkOutput("midRstCount", 32'(timeoutCount), 0);
        @(negedge clk);
        checkOutput("midRstNoValid", 32'(bus.rsp_valid), 0);
        rstN = 1'b1;
        laneCode[1] = SR_DVA;
        bus.wci_SData[32*1 +: 32] = 32'h0BADF00D;
        applyStimulus(3'd1, 1'b0, 1'b0, 32'h24, 32'h0, 4'hF);
        checkOutput("postRstLatency", gotLat, 3);
        checkOutput("postRstCmdLanes", cmdValue, 32'h10);
        checkOutput("postRstStatus", gotStatus, 0);
        checkOutput("postRstData", gotData, 32'h0BADF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wci_ctl_sequencer.md
# wci_ctl_sequencer

Control-plane sequencer for the eight WCI slave ports of the generic application container. It accepts one host request at a time, aimed at one of eight workers, and issues it as a single OCP read or write on that worker's WCI port. It waits for thread-busy to clear, then for the response, and returns the result with an OK, ERR or TIMEOUT status. Workers that time out are fenced off until software clears them.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: maximum wait cycles for each of the busy and response phases; range 2..65535.

Ports:
- CLK  in  1  sole clock
- RST_N  in  1  reset, asynchronous, active-low
- req_valid  in  1  host request valid
- req_ready  out  1  sequencer idle, request accepted when req_valid && req_ready
- req_worker  in  3  target worker index 0..7
- req_write  in  1  1=write, 0=read
- req_space  in  1  0=control space, 1=configuration space; drives MAddrSpace
- req_addr  in  32  byte address
- req_data  in  32  write data
- req_byteen  in  4  byte enables
- rsp_valid  out  1  one-cycle completion strobe
- rsp_data  out  32  read data; 0 for writes and errors
- rsp_status  out  2  0=OK, 1=ERR (SResp FAIL/ERR), 2=TIMEOUT, 3=FENCED
- clear_dead  in  1  pulse that clears all worker_dead bits
- worker_dead  out  8  sticky per-worker timeout fence
- timeout_count  out  16  saturating timeout counter; see Configuration
- wci_MCmd  out  24  3 bits per worker, worker i at [3i+2:3i]; IDLE=0, WR=1, RD=2
- wci_MAddrSpace  out  1  shared
- wci_MByteEn  out  4  shared
- wci_MAddr  out  32  shared
- wci_MData  out  32  shared
- wci_SResp  in  16  2 bits per worker; NULL=0, DVA=1, FAIL=2, ERR=3
- wci_SData  in  256  32 bits per worker
- wci_SThreadBusy  in  8  per worker

## Operation
States: IDLE, BUSYWAIT, CMD, RESP, DONE.
- IDLE: req_ready=1. On accept, the sequencer latches the request and clears the wait counter.
  - If worker_dead[req_worker]=1, go to DONE with status FENCED. No bus activity occurs.
  - Otherwise go to BUSYWAIT.
- BUSYWAIT: wait for wci_SThreadBusy[w]=0, then go to CMD.
  - The wait counter increments each cycle.
  - If the counter reaches TIMEOUT_CYCLES: go to DONE with TIMEOUT and set worker_dead[w].
- CMD: drive wci_MCmd lane w to WR or RD for exactly one cycle. All other lanes stay IDLE. Clear the counter and go to RESP.
- RESP: sample wci_SResp lane w.
  - DVA: capture rsp_data (reads only), status OK.
  - FAIL or ERR: status ERR.
  - NULL: increment the counter. At TIMEOUT_CYCLES, status TIMEOUT and set worker_dead[w].
- DONE: rsp_valid=1 for one cycle, then go to IDLE.
- Shared address, data, byteen and space outputs hold the latched request from accept until the return to IDLE. In IDLE they are 0.
- A response on a worker lane other than w is ignored.
- clear_dead and a new timeout in the same cycle: the new timeout bit wins (set has priority over clear).
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_status=0, worker_dead=0, timeout_count=0, all wci_MCmd lanes IDLE, shared outputs 0, state IDLE.
- Asserting RST_N mid-transaction aborts it immediately: no rsp_valid, MCmd returns to IDLE.

## Timing
- Request accepted at edge k. With busy already clear: CMD at k+1, MCmd visible in cycle k+1.
- Earliest response in cycle k+2 gives rsp_valid in cycle k+3. Best-case latency is accept to rsp_valid = 3 cycles.
- Fenced request: rsp_valid one cycle after accept.
- Timeout: exactly TIMEOUT_CYCLES cycles in the failing phase, then DONE.
- req_ready is 0 from the cycle after accept until the cycle after DONE.
- At most one request is outstanding; there is no pipelining.

## Configuration
- WCI_SEQ_TOCOUNT_EN defined: timeout_count increments on every TIMEOUT completion, saturates at 0xFFFF, and is cleared only by reset.
- WCI_SEQ_TOCOUNT_EN undefined: no counter logic; timeout_count is tied to 0. Fencing is unaffected.

## Test plan
- Read worker 3, addr 0x10, busy low, SResp=DVA with SData=0xCAFEF00D one cycle after CMD -> MCmd lane 3 = RD for 1 cycle; rsp_status=0, rsp_data=0xCAFEF00D, latency 3.
- Write worker 0, data 0x12345678, byteen 0xF, space 1 -> MData=0x12345678, MAddrSpace=1 during CMD; DVA gives status 0, rsp_data=0.
- Worker 5 busy held high, TIMEOUT_CYCLES=16 -> no MCmd issued; rsp_status=2 after 16 cycles; worker_dead=0x20; timeout_count=1 with the macro, 0 without.
- Next request to worker 5 -> rsp_status=3 one cycle after accept with no bus activity. After a clear_dead pulse, a request proceeds normally.
- Worker 2 returns SResp=ERR -> rsp_status=1, worker_dead unchanged. A DVA injected on lane 4 during a worker 2 wait is ignored.
- RST_N low during RESP -> all outputs return to reset values asynchronously with no rsp_valid; a subsequent request completes normally.
